// File: rtl/soc_mmio_pkg.sv
// ----------------------------------------------------------------------------
// soc_mmio_pkg
//  Shared definitions for the SoC peripheral-bus master path:
//   - address/data/counter widths
//   - default MMIO map window and well-known peripheral addresses
//   - bridge FSM state encoding
//   - address legality helper (alignment + inclusive window, unsigned)
// ----------------------------------------------------------------------------
package soc_mmio_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;   // wait counter, covers 0..15 wait cycles

   localparam logic [ADDR_W-1:0] MMIO_MAP_BASE  = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] MMIO_MAP_LIMIT = 32'h0000_00FF;
   localparam logic [ADDR_W-1:0] GPIO_ADDR      = 32'h0000_0030;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Word-aligned and inside [base, limit]; limit is inclusive, compare unsigned.
   function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] limit);
      return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= limit);
   endfunction

endpackage

// File: rtl/mmio_req_bridge.sv
// ----------------------------------------------------------------------------
// mmio_req_bridge
//  Converts core load/store requests (valid/ready) into single-word MMIO
//  accesses. Illegal requests (misaligned / outside the map) are answered
//  with an error response and never reach the bus. Legal requests hold the
//  bus for WAIT_CYCLES+1 cycles; stores pulse bus_we in the last of these,
//  loads sample bus_rdata at the end of it. One request outstanding at a time.
//
// Ports
//  clk        in   clock, rising edge
//  rst        in   synchronous reset, active low
//  req_valid  in   request present          req_ready  out  request accepted
//  req_addr   in   byte address             req_wdata  in   store data
//  req_we     in   1 = store, 0 = load
//  resp_valid out  response present         resp_ready in   response taken
//  resp_rdata out  load data (0 for stores / errors)
//  resp_err   out  misaligned or out-of-range
//  bus_addr   out  decoder address          bus_wdata  out  decoder write data
//  bus_we     out  decoder write strobe     bus_rdata  in   decoder read data
// ----------------------------------------------------------------------------
module mmio_req_bridge
   import soc_mmio_pkg::*;
#(
   parameter int unsigned       WAIT_CYCLES = 1,
   parameter logic [ADDR_W-1:0] MAP_BASE    = MMIO_MAP_BASE,
   parameter logic [ADDR_W-1:0] MAP_LIMIT   = MMIO_MAP_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_we,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_we,
   input  logic [DATA_W-1:0] bus_rdata
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;

   logic in_access;
   logic final_cycle;

   assign in_access   = (state_q == ST_ACCESS);
   assign final_cycle = in_access && (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && ready_q) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               we_d    = req_we;
               if (addr_legal(req_addr, MAP_BASE, MAP_LIMIT)) begin
                  state_d = ST_ACCESS;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
               end else begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : bus_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered so that req_ready stays low in the reset cycle and
      // rises only in the cycle after the response handshake.
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Bus is zero outside ACCESS so an idle decoder reads back 0.
   assign bus_addr  = in_access ? addr_q  : '0;
   assign bus_wdata = in_access ? wdata_q : '0;
   // Gated by rst so a store whose final cycle meets reset is not committed.
   assign bus_we    = final_cycle && we_q && rst;

endmodule
